// File: rtl/uart_pkg.sv
// Shared UART definitions for the SnakeWars board-to-board link (rx today, tx later).
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_e;

  localparam int UART_CLK_FREQ   = 75_000_000;
  localparam int UART_BAUD       = 115_200;
  localparam int UART_OVERSAMPLE = 16;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int uart_tick_div(input int clk_freq, input int baud);
    return (clk_freq + baud * UART_OVERSAMPLE / 2) / (baud * UART_OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_link_rx_if.sv
// Byte handshake from the UART receiver to the game link layer, plus error pulses.
interface uart_link_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle tick every DIV clocks. Never re-phased.
module uart_baud_tick #(
  parameter int DIV = 41
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == W'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_link_rx.sv
// 8N1 UART receiver, 16x oversampling, mid-bit sampling, valid/ready byte output.
module uart_link_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = UART_CLK_FREQ,
  parameter int BAUD     = UART_BAUD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_link_rx_if.master link
);
  localparam int TICK_DIV = uart_tick_div(CLK_FREQ, BAUD);

  (* ASYNC_REG = "TRUE" *) logic rx_meta_q;
  (* ASYNC_REG = "TRUE" *) logic rx_s_q;

  logic           tick;
  uart_rx_state_e state_q, state_d;
  logic [3:0]     os_cnt_q, os_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;
  logic           deliver;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (valid_q && link.rx_ready) valid_d = 1'b0;

    if (tick) begin
      os_cnt_d = os_cnt_q + 4'd1;
      case (state_q)
        IDLE: begin
          os_cnt_d = '0;
          if (!rx_s_q) state_d = START;
        end
        // Start bit re-checked at mid-bit so short glitches fall back to IDLE.
        START: if (os_cnt_q == 4'd7) begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
        DATA: if (os_cnt_q == 4'd15) begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d  = STOP;
            os_cnt_d = '0;
          end
        end
        STOP: if (os_cnt_q == 4'd15) begin
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
        BREAK: begin
          os_cnt_d = '0;
          if (rx_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // A byte accepted this cycle frees the register for the new one.
    if (deliver) begin
      if (!valid_q || link.rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign link.rx_data   = data_q;
  assign link.rx_valid  = valid_q;
  assign link.frame_err = frame_err_q;
  assign link.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_link_rx.sv
// Directed bench for uart_link_rx: 1.6 MHz clock, 10 kbaud -> 160 clk per bit.
module tb_uart_link_rx;
  import uart_pkg::*;

  localparam int BIT = 160;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_link_rx_if lif();

  uart_link_rx #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .link (lif)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Pops one expected byte per handshake; also tallies error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (lif.frame_err) fe_cnt++;
      if (lif.overrun)   ov_cnt++;
      if (lif.rx_valid && lif.rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got %02h want none", lif.rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (lif.rx_data !== mon_exp) begin
            errors++;
            $display("FAIL rx_data got %02h want %02h", lif.rx_data, mon_exp);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    wait_clk(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int bc);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
    drive_bit(stop, bc);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    lif.rx_ready = 1'b0;
    wait_clk(3);
    check("reset_valid", lif.rx_valid, 0);
    check("reset_data", lif.rx_data, 0);
    check("reset_frame_err", lif.frame_err, 0);
    check("reset_overrun", lif.overrun, 0);
    check("reset_state", int'(dut.state_q), int'(IDLE));
    rst = 1'b0;
    wait_clk(BIT);

    // 1: single byte, consumer ready
    lif.rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, BIT);
    wait_clk(BIT);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_frame_err", fe_cnt, 0);
    check("t1_overrun", ov_cnt, 0);

    // 2: consumer stalled, second byte overruns
    lif.rx_ready = 1'b0;
    send_byte(8'h3C, 1'b1, BIT);
    send_byte(8'h81, 1'b1, BIT);
    wait_clk(BIT);
    check("t2_valid_held", lif.rx_valid, 1);
    check("t2_data_held", lif.rx_data, 8'h3C);
    check("t2_overrun", ov_cnt, 1);
    exp_q.push_back(8'h3C);
    lif.rx_ready = 1'b1;
    wait_clk(1);
    check("t2_valid_drop", lif.rx_valid, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: bad stop bit, long break, then a good frame
    send_byte(8'h55, 1'b0, BIT);
    drive_bit(1'b0, 20 * BIT);
    drive_bit(1'b1, 2 * BIT);
    check("t3_frame_err", fe_cnt, 1);
    check("t3_no_valid", lif.rx_valid, 0);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, BIT);
    wait_clk(BIT);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: 3-tick glitch on idle line
    drive_bit(1'b0, 30);
    drive_bit(1'b1, 2 * BIT);
    check("t4_state_idle", int'(dut.state_q), int'(IDLE));
    check("t4_no_valid", lif.rx_valid, 0);
    check("t4_frame_err", fe_cnt, 1);

    // 5: reset in the middle of data bit 4 of 0xFF
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
    drive_bit(1'b1, BIT / 2);
    rst = 1'b1;
    wait_clk(1);
    check("t5_valid", lif.rx_valid, 0);
    check("t5_data", lif.rx_data, 0);
    check("t5_frame_err", lif.frame_err, 0);
    check("t5_overrun", lif.overrun, 0);
    rst = 1'b0;
    drive_bit(1'b1, BIT / 2 + 4 * BIT + BIT);
    check("t5_no_valid_after", lif.rx_valid, 0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, BIT);
    wait_clk(BIT);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: back-to-back at +2% then -2% baud
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h5A);
      send_byte(8'h00, 1'b1, r == 0 ? 157 : 163);
      send_byte(8'hFF, 1'b1, r == 0 ? 157 : 163);
      send_byte(8'h5A, 1'b1, r == 0 ? 157 : 163);
      wait_clk(2 * BIT);
      check("t6_queue_empty", exp_q.size(), 0);
    end
    check("t6_frame_err", fe_cnt, 1);
    check("t6_overrun", ov_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
